// File: rtl/reg_dump.sv
// reg_dump: walks an inclusive, wrapping address range of an external register
// file and presents each register as a valid/ready word.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a dump (only looked at while idle)
//   lo_addr    first register index, latched on start
//   hi_addr    last register index (inclusive), latched on start
//   rd_addr    read address to the register file
//   rd_data    combinational read data for rd_addr
//   out_valid  out_addr/out_data hold a word
//   out_ready  consumer accepts the word while out_valid=1
//   out_addr   index of the presented word
//   out_data   captured contents of the presented word
//   busy       high whenever not idle
//   done       single-cycle pulse after the last word is accepted
//
// state | meaning
// IDLE  | waiting for start
// READ  | rd_addr=ptr, capture into the output register at the next edge
// SEND  | word presented, waiting for out_ready
// DONE  | last word accepted, done pulse for one cycle

module reg_dump #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] lo_addr,
  input  logic [ADDRESS_WIDTH-1:0] hi_addr,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] ptr, ptr_nxt;
  logic [ADDRESS_WIDTH-1:0] end_reg, end_nxt;
  logic                     valid_nxt;
  logic [ADDRESS_WIDTH-1:0] oaddr_nxt;
  logic [DATA_WIDTH-1:0]    odata_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      end_reg   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      end_reg   <= end_nxt;
      out_valid <= valid_nxt;
      out_addr  <= oaddr_nxt;
      out_data  <= odata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    end_nxt   = end_reg;
    valid_nxt = out_valid;
    oaddr_nxt = out_addr;
    odata_nxt = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_nxt   = lo_addr;
          end_nxt   = hi_addr;
          state_nxt = READ;
        end
      end
      READ: begin
        // rd_data is sampled at this edge, so a same-edge write to the
        // register file cannot leak into the captured word.
        odata_nxt = rd_data;
        oaddr_nxt = ptr;
        valid_nxt = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (ptr == end_reg) begin
            state_nxt = DONE;
          end else begin
            // natural overflow gives the wrap from the top index back to 0
            ptr_nxt   = ptr + 1'b1;
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rd_addr = ptr;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  lo_addr;
  logic [4:0]  hi_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  // bench register file: one write port, combinational read
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] regs [32];
  logic [31:0] snap [32];  // contents as they were just before the latest edge

  int checks = 0;
  int errors = 0;

  reg_dump #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lo_addr   (lo_addr),
    .hi_addr   (hi_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    snap <= regs;
    if (we) regs[waddr] <= wdata;
  end

  assign rd_data = regs[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // caller must be positioned just after a falling edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Runs one dump and checks it against the range arithmetic.
  // rmode: 0 ready always 1, 1 random ready, 2 ready low for 5 cycles per word
  // wmode: 0 no writes, 1 random writes (incl. the word being read), 2 overwrite held word
  // Caller must be positioned just after a falling edge.
  task automatic run_dump(input logic [4:0] lo, input logic [4:0] hi,
                          input int rmode, input int wmode, input bit repulse);
    int n, idx, cyc, last_new, hold_cnt, words;
    bit hs, prev_valid, finished;
    logic [4:0]  ha, ea;
    logic [31:0] hd;
    n = ((int'(hi) - int'(lo) + 32) % 32) + 1;
    idx = 0; cyc = 0; last_new = 0; hold_cnt = 0; words = 0;
    hs = 1'b0; prev_valid = 1'b0; finished = 1'b0;
    ha = '0; hd = '0;
    lo_addr = lo; hi_addr = hi; start = 1'b1; out_ready = 1'b0; we = 1'b0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hs) begin
        hs = 1'b0;
        idx++;
        chk("valid_drop", {31'b0, out_valid}, 32'd0);
        if (idx == n) begin
          chk("done_pulse", {31'b0, done}, 32'd1);
          chk("busy_in_done", {31'b0, busy}, 32'd1);
          start = 1'b0; out_ready = 1'b0; we = 1'b0;
          @(negedge clk);
          chk("done_once", {31'b0, done}, 32'd0);
          chk("busy_idle", {31'b0, busy}, 32'd0);
          chk("word_count", words, n);
          finished = 1'b1;
        end
      end else if (out_valid) begin
        if (!prev_valid) begin
          ea = 5'((int'(lo) + idx) % 32);
          chk("addr", {27'b0, out_addr}, {27'b0, ea});
          chk("data", out_data, snap[ea]);
          if (idx == 0) chk("first_latency", cyc, 2);
          else if (rmode == 0) chk("throughput", cyc - last_new, 2);
          last_new = cyc; ha = ea; hd = snap[ea]; hold_cnt = 0; words++;
        end else begin
          chk("hold_addr", {27'b0, out_addr}, {27'b0, ha});
          chk("hold_data", out_data, hd);
          chk("rd_addr_send", {27'b0, rd_addr}, {27'b0, ha});
        end
      end
      if (!finished) begin
        chk("busy", {31'b0, busy}, 32'd1);
        chk("no_early_done", {31'b0, done}, 32'd0);
        prev_valid = out_valid;
        start = repulse && (cyc == 3);
        lo_addr = 5'($urandom);
        hi_addr = 5'($urandom);
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom % 2);
          default: out_ready = out_valid && (hold_cnt >= 5);
        endcase
        if (out_valid) hold_cnt++;
        hs = out_valid && out_ready;
        case (wmode)
          1: begin
            we    = 1'($urandom % 2);
            waddr = out_valid ? 5'($urandom) : 5'((int'(lo) + idx) % 32);
            wdata = $urandom;
          end
          2: begin
            we    = out_valid && !out_ready;
            waddr = ha;
            wdata = 32'hFFFF_FFFF;
          end
          default: we = 1'b0;
        endcase
      end
    end
    chk("dump_complete", {31'b0, finished}, 32'd1);
  endtask

  initial begin
    logic [4:0] rl, rh;
    rst_n = 1'b0; start = 1'b0; lo_addr = '0; hi_addr = '0;
    out_ready = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_out_addr", {27'b0, out_addr}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_rd_addr", {27'b0, rd_addr}, 32'd0);

    @(negedge clk);
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 4));
    wr(5'd10, 32'h0000_002A);
    rst_n = 1'b1;

    run_dump(5'd10, 5'd10, 0, 0, 1'b0);          // single word, x10=0x2A
    wr(5'd10, 32'd40);
    run_dump(5'd0, 5'd31, 0, 0, 1'b0);           // full in-order dump
    run_dump(5'd30, 5'd1, 1, 0, 1'b0);           // wrap: 30,31,0,1
    run_dump(5'd3, 5'd3, 2, 2, 1'b0);            // hold while x3 overwritten
    run_dump(5'd20, 5'd25, 0, 0, 1'b1);          // start re-pulsed while busy
    run_dump(5'd7, 5'd6, 1, 1, 1'b1);            // full 32 words via hi=lo-1

    for (int t = 0; t < 8; t++) begin
      rl = 5'($urandom);
      rh = 5'($urandom);
      run_dump(rl, rh, int'($urandom % 2), int'($urandom % 2), 1'($urandom % 2));
    end

    // reset in the middle of a 32-word dump
    lo_addr = 5'd0; hi_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_done", {31'b0, done}, 32'd0);
    chk("async_out_addr", {27'b0, out_addr}, 32'd0);
    chk("async_out_data", out_data, 32'd0);
    chk("async_rd_addr", {27'b0, rd_addr}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", {31'b0, done}, 32'd0);
    end
    rst_n = 1'b1;
    run_dump(5'd5, 5'd5, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
